random_range: RTL
=================

# random_range

Parametrised Galois-LFSR pseudo-random source with a handshaked bounded-range draw unit. It supplies the free-running `number` word to game logic and answers `req` with a uniformly distributed `value` in the inclusive range [`lo`, `hi`]. It is used for pipe gap heights and spawn spacing. It is the generalised successor of the fixed 32-bit generator: width, taps and default seed are parameters, and it adds zero-seed protection, step enable and rejection-sampled range output.

## Interface
- `WIDTH`, 32: LFSR state width; 8..64.
- `TAPS`, 32'h8020_0003: Galois feedback mask, maximal-length for `WIDTH`=32.
- `DEFAULT_SEED`, 32'h4789_FA12: state after reset and substitute for a zero seed; must be nonzero.
- `OUT_W`, 10: range operand/result width; `OUT_W` <= `WIDTH`.
- `MAX_TRIES`, 8: rejected draws allowed before the fallback path is taken.
- `clk`, in, 1: single clock; all state on rising edge.
- `rstn`, in, 1: reset, asynchronous, active-low.
- `seed`, in, `WIDTH`: seed value, sampled only when `seed_load`=1.
- `seed_load`, in, 1: synchronous seed load strobe.
- `step_en`, in, 1: advance LFSR one step per cycle while idle.
- `req`, in, 1: range draw request, sampled in IDLE only.
- `lo`, in, `OUT_W`: range lower bound, latched on accepted `req`.
- `hi`, in, `OUT_W`: range upper bound, latched on accepted `req`.
- `busy`, out, 1: draw in progress (state != IDLE).
- `valid`, out, 1: one-cycle pulse; `value` is fresh.
- `value`, out, `OUT_W`: last drawn result, held until next `valid`.
- `number`, out, `WIDTH`: current LFSR state.

## Operation
- Reset values: LFSR = `DEFAULT_SEED`, state IDLE, `busy`=0, `valid`=0, `value`=0, latched bounds 0.
- LFSR step (right-shift Galois): b = s[0]; s = s >> 1; if b, s ^= `TAPS`.
- LFSR update priority per cycle:
  - `seed_load` loads `seed`, or `DEFAULT_SEED` if `seed`==0.
  - Otherwise the LFSR steps if state==DRAW or `step_en`=1.
  - Otherwise it holds.
- The state can never become zero.
- FSM states:
  - IDLE: on `req`, latch `lo`/`hi`, swapping them if `lo` > `hi`, then go to MASK. `req` is ignored in all other states, with no queueing.
  - MASK: compute d = hi−lo (`OUT_W` bits) and mask = smallest 2^k−1 >= d (d=0 gives mask=0). Clear the try counter. Go to DRAW.
  - DRAW: cand = `number`[OUT_W−1:0] & mask.
    - If cand <= d: `value` = lo+cand, pulse `valid`, go to IDLE.
    - Else if tries == `MAX_TRIES`−1: `value` = lo+(cand>>1), which is always < d+1; pulse `valid`, go to IDLE.
    - Else: increment tries and stay in DRAW.
    - The LFSR steps every DRAW cycle.
- Arithmetic: lo+cand <= hi, so it never overflows `OUT_W`. There is no wrap-around.
- `seed_load` during DRAW: the load wins that cycle, and the draw continues from the loaded state. The draw is not aborted.
- `rstn` low mid-draw: immediate return to reset values. No `valid` is produced for the aborted draw.

## Timing
- `req` sampled at edge N:
  - MASK after N.
  - DRAW after N+1.
  - First candidate evaluated at edge N+2.
  - With first-try acceptance, `valid`=1 and the new `value` are visible during the cycle following edge N+2, i.e. latency 3 cycles.
- Each rejection adds 1 cycle. Worst case latency is 2+`MAX_TRIES` cycles.
- `busy` rises after edge N and falls on the same edge that raises `valid`.
- A new `req` is accepted in the cycle `valid` is high, because the FSM is then in IDLE.
- `seed_load` at edge M: `number` shows the loaded value after M.
- `number` changes at most once per cycle.

## Structure
- Shared package/header `random_pkg`: FSM state encoding (IDLE, MASK, DRAW), and default TAPS constants for widths 16, 32 and 64.
- Sub-module `lfsr_core`:
  - Parameters: `WIDTH`, `TAPS`, `DEFAULT_SEED`.
  - Ports: `clk`, `rstn`, `load`, `load_val`, `step`, `state`.
  - Contains the zero-seed substitution.
- Top level: FSM, mask generation, try counter and output registers.

## Test plan
- Reset, then hold `step_en`=1 for 2 cycles. Required `number` sequence: 32'h4789_FA12, 32'h23C4_FD09, 32'h91C2_7E87.
- `seed_load`=1 with `seed`=0. Required: `number`=32'h4789_FA12 the next cycle, and it never becomes 0 over 10^5 steps. Also check that no state repeats within 2^20 steps.
- `lo`=`hi`=37, `req` at edge N. Required: `valid` after N+2, `value`=37, `busy` high for exactly 2 cycles.
- `lo`=16, `hi`=47 (d=31, mask=31). Required: every draw is accepted on the first try, latency is exactly 3 cycles, and the results over 4096 draws fall within 16..47 with each bin hit.
- `lo`=0, `hi`=512 (mask=1023) over 10^4 draws. Required:
  - every value <= 512;
  - no draw longer than 2+`MAX_TRIES` cycles;
  - `lo`=200 with `hi`=100 yields values in 100..200.
- Drop `rstn` during DRAW. Required: `busy`=0, `valid`=0, `value`=0 and `number`=`DEFAULT_SEED` immediately. Pulsing `req` while busy causes no extra `valid`.

Source files
------------

// File: rtl/random_pkg.sv
// Shared definitions for the random_range generator: FSM encoding and
// known-good Galois feedback masks for common LFSR widths.
package random_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MASK = 2'd1,
    ST_DRAW = 2'd2
  } rr_state_e;

  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;
  localparam logic [63:0] TAPS_64 = 64'hD800_0000_0000_0000;

  // Falls back to the 32-bit mask for widths without a tabulated polynomial.
  function automatic logic [63:0] default_taps(input int w);
    case (w)
      16:      return {48'd0, TAPS_16};
      64:      return TAPS_64;
      default: return {32'd0, TAPS_32};
    endcase
  endfunction

endpackage

// File: rtl/random_range_lfsr_core.sv
// Right-shift Galois LFSR with seed load, step enable and zero-seed
// substitution so the register can never enter the all-zero lock-up state.
module lfsr_core #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(32'h8020_0003),
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(32'h4789_FA12)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] step_d;
  logic [WIDTH-1:0] load_d;

  assign step_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
  assign load_d = (load_val == '0) ? DEFAULT_SEED : load_val;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= DEFAULT_SEED;
    end else if (load) begin
      state_q <= load_d;
    end else if (step) begin
      state_q <= step_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/random_range.sv
// Free-running LFSR source plus a handshaked draw unit returning a uniform
// value in [lo, hi] by rejection sampling with a bounded retry fallback.
module random_range
  import random_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(32'h4789_FA12),
  parameter int               OUT_W        = 10,
  parameter int               MAX_TRIES    = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] seed,
  input  logic             seed_load,
  input  logic             step_en,
  input  logic             req,
  input  logic [OUT_W-1:0] lo,
  input  logic [OUT_W-1:0] hi,
  output logic             busy,
  output logic             valid,
  output logic [OUT_W-1:0] value,
  output logic [WIDTH-1:0] number
);

  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  // Smear the top set bit downward: smallest all-ones mask covering d.
  function automatic logic [OUT_W-1:0] span_mask(input logic [OUT_W-1:0] d);
    logic [OUT_W-1:0] m;
    m = d;
    for (int i = 1; i < OUT_W; i = i * 2) begin
      m = m | (m >> i);
    end
    return m;
  endfunction

  rr_state_e        state_q;
  logic [OUT_W-1:0] lo_q, hi_q, diff_q, mask_q, value_q;
  logic [TRY_W-1:0] tries_q;
  logic             valid_q;

  logic [OUT_W-1:0] diff_d;
  logic [OUT_W-1:0] cand_d;
  logic             lfsr_step;

  assign lfsr_step = (state_q == ST_DRAW) || step_en;
  assign diff_d    = hi_q - lo_q;
  assign cand_d    = number[OUT_W-1:0] & mask_q;

  lfsr_core #(
    .WIDTH        (WIDTH),
    .TAPS         (TAPS),
    .DEFAULT_SEED (DEFAULT_SEED)
  ) u_lfsr (
    .clk      (clk),
    .rstn     (rstn),
    .load     (seed_load),
    .load_val (seed),
    .step     (lfsr_step),
    .state    (number)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      diff_q  <= '0;
      mask_q  <= '0;
      value_q <= '0;
      tries_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            lo_q    <= (lo > hi) ? hi : lo;
            hi_q    <= (lo > hi) ? lo : hi;
            state_q <= ST_MASK;
          end
        end
        ST_MASK: begin
          diff_q  <= diff_d;
          mask_q  <= span_mask(diff_d);
          tries_q <= '0;
          state_q <= ST_DRAW;
        end
        ST_DRAW: begin
          if (cand_d <= diff_q) begin
            value_q <= lo_q + cand_d;
            valid_q <= 1'b1;
            state_q <= ST_IDLE;
          end else if (tries_q == LAST_TRY) begin
            // mask < 2*(d+1), so halving a rejected candidate lands inside the range.
            value_q <= lo_q + (cand_d >> 1);
            valid_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            tries_q <= tries_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign valid = valid_q;
  assign value = value_q;

endmodule
